// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants and padder state encoding for the SHA256 front end
package sha256_pkg;

  localparam int SHA_WORD_W      = 32;
  localparam int SHA_BLOCK_WORDS = 16;
  localparam int SHA_LEN_IDX_HI  = 14;
  localparam int SHA_LEN_IDX_LO  = 15;
  localparam logic [7:0] SHA_PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAD1,
    ZERO,
    LEN_HI,
    LEN_LO
  } padder_state_t;

endpackage

// File: rtl/sha256_msg_padder_if.sv
// rtl/sha256_msg_padder_if.sv - byte-stream input and padded-word output handshake bundle
interface sha256_msg_padder_if
  import sha256_pkg::*;
#(
  parameter int IN_BYTES = 1
);

  localparam int BW = $clog2(IN_BYTES + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic [8*IN_BYTES-1:0]   in_data;
  logic [BW-1:0]           in_bytes;
  logic                    in_last;
  logic                    word_valid;
  logic                    word_ready;
  logic [SHA_WORD_W-1:0]   word_data;
  logic [3:0]              word_index;
  logic                    msg_last;

  // padder side
  modport slave (
    input  in_valid, in_data, in_bytes, in_last, word_ready,
    output in_ready, word_valid, word_data, word_index, msg_last
  );

  // message source / word sink side
  modport master (
    output in_valid, in_data, in_bytes, in_last, word_ready,
    input  in_ready, word_valid, word_data, word_index, msg_last
  );

endinterface

// File: rtl/sha256_word_packer.sv
// rtl/sha256_word_packer.sv - MSB-first byte-to-word accumulator with message byte count
module sha256_word_packer
  import sha256_pkg::*;
#(
  parameter int IN_BYTES  = 1,
  parameter int MSG_CNT_W = 32,
  localparam int BW = $clog2(IN_BYTES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [8*IN_BYTES-1:0] i_data,
  input  logic [BW-1:0]         i_bytes,
  input  logic                  i_flush,
  input  logic                  i_clear,
  output logic                  o_word_done,
  output logic [SHA_WORD_W-1:0] o_word,
  output logic [SHA_WORD_W-1:0] o_pad_word,
  output logic [MSG_CNT_W-1:0]  o_byte_cnt
);

  logic [SHA_WORD_W-1:0] r_acc;
  logic [2:0]            r_fill;
  logic [MSG_CNT_W-1:0]  r_byte_cnt;
  logic [SHA_WORD_W-1:0] w_merged;
  logic [3:0]            w_sum;

  // Legal beats never straddle a word: IN_BYTES divides 4 and only the last beat is short.
  assign w_sum       = 4'(r_fill) + 4'(i_bytes);
  assign o_word_done = i_push && (w_sum == 4'd4);
  assign o_word      = w_merged;
  assign o_pad_word  = r_acc | ({SHA_PAD_BYTE, 24'h0} >> {r_fill, 3'b000});
  assign o_byte_cnt  = r_byte_cnt;

  // Drop the incoming bytes into the free byte lanes right after the current fill level.
  always_comb begin
    w_merged = r_acc;
    for (int j = 0; j < IN_BYTES; j++) begin
      if ((j < int'(i_bytes)) && ((int'(r_fill) + j) < 4)) begin
        w_merged[31-8*(int'(r_fill)+j) -: 8] = i_data[8*(IN_BYTES-j)-1 -: 8];
      end
    end
  end

  // Accumulator, fill level and wrapping byte counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc      <= '0;
      r_fill     <= '0;
      r_byte_cnt <= '0;
    end else if (i_clear) begin
      r_acc      <= '0;
      r_fill     <= '0;
      r_byte_cnt <= '0;
    end else if (i_push) begin
      r_byte_cnt <= r_byte_cnt + MSG_CNT_W'(i_bytes);
      if (w_sum == 4'd4) begin
        r_acc  <= '0;
        r_fill <= '0;
      end else begin
        r_acc  <= w_merged;
        r_fill <= w_sum[2:0];
      end
    end else if (i_flush) begin
      r_acc  <= '0;
      r_fill <= '0;
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - SHA256 message padder emitting 32-bit padded block words
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int IN_BYTES  = 1,
  parameter int MSG_CNT_W = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  sha256_msg_padder_if.slave     io_bus
);

  padder_state_t         r_state;
  padder_state_t         w_next;
  logic                  r_rdy_en;
  logic                  r_out_valid;
  logic [SHA_WORD_W-1:0] r_out_data;
  logic [3:0]            r_out_idx;
  logic                  r_out_last;
  logic [3:0]            r_next_idx;

  logic                  w_out_free;
  logic                  w_in_ready;
  logic                  w_in_fire;
  logic                  w_load;
  logic [SHA_WORD_W-1:0] w_load_data;
  logic                  w_load_last;
  logic                  w_flush;
  logic                  w_clear;
  logic                  w_pk_done;
  logic [SHA_WORD_W-1:0] w_pk_word;
  logic [SHA_WORD_W-1:0] w_pk_pad;
  logic [MSG_CNT_W-1:0]  w_byte_cnt;
  logic [63:0]           w_bitlen;

  localparam logic [3:0] LAST_ZERO_IDX = 4'(SHA_LEN_IDX_HI - 1);

  assign w_out_free = !r_out_valid || io_bus.word_ready;
  assign w_in_ready = r_rdy_en && ((r_state == IDLE) || (r_state == DATA)) && w_out_free;
  assign w_in_fire  = io_bus.in_valid && w_in_ready;
  assign w_bitlen   = {{(64-MSG_CNT_W-3){1'b0}}, w_byte_cnt, 3'b000};

  assign io_bus.in_ready   = w_in_ready;
  assign io_bus.word_valid = r_out_valid;
  assign io_bus.word_data  = r_out_data;
  assign io_bus.word_index = r_out_idx;
  assign io_bus.msg_last   = r_out_last;

  sha256_word_packer #(
    .IN_BYTES  (IN_BYTES),
    .MSG_CNT_W (MSG_CNT_W)
  ) u_packer (
    .i_clk       (i_clock),
    .i_rst_n     (i_reset),
    .i_push      (w_in_fire),
    .i_data      (io_bus.in_data),
    .i_bytes     (io_bus.in_bytes),
    .i_flush     (w_flush),
    .i_clear     (w_clear),
    .o_word_done (w_pk_done),
    .o_word      (w_pk_word),
    .o_pad_word  (w_pk_pad),
    .o_byte_cnt  (w_byte_cnt)
  );

  // State register; input acceptance is held off for the first cycle after reset release.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= IDLE;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rdy_en <= 1'b1;
    end
  end

  // Next state and the word to load into the output register this cycle.
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_load_data = '0;
    w_load_last = 1'b0;
    w_flush     = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE, DATA: begin
        if (w_in_fire) begin
          if (w_pk_done) begin
            w_load      = 1'b1;
            w_load_data = w_pk_word;
          end
          w_next = io_bus.in_last ? PAD1 : DATA;
        end
      end
      PAD1: begin
        if (w_out_free) begin
          w_load      = 1'b1;
          w_load_data = w_pk_pad;
          w_flush     = 1'b1;
          w_next      = (r_next_idx == LAST_ZERO_IDX) ? LEN_HI : ZERO;
        end
      end
      ZERO: begin
        if (w_out_free) begin
          w_load = 1'b1;
          if (r_next_idx == LAST_ZERO_IDX) w_next = LEN_HI;
        end
      end
      LEN_HI: begin
        if (w_out_free) begin
          w_load      = 1'b1;
          w_load_data = w_bitlen[63:32];
          w_next      = LEN_LO;
        end
      end
      LEN_LO: begin
        // The length word is loaded once; the state is left only when it has been taken.
        if (r_out_valid && r_out_last) begin
          if (io_bus.word_ready) begin
            w_clear = 1'b1;
            w_next  = IDLE;
          end
        end else if (w_out_free) begin
          w_load      = 1'b1;
          w_load_data = w_bitlen[31:0];
          w_load_last = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Output register: holds its word while stalled, word index advances per loaded word.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_next_idx  <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_load_data;
      r_out_idx   <= r_next_idx;
      r_out_last  <= w_load_last;
      r_next_idx  <= r_next_idx + 4'd1;
    end else if (io_bus.word_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - scoreboard and vector-table bench for sha256_msg_padder
module tb_sha256_msg_padder;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  typedef struct {
    int          len;
    bit          is_abc;
    logic [31:0] w0;
    logic [31:0] wlast;
    int          nwords;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_msg_padder_if #(.IN_BYTES(1)) bus1 ();
  sha256_msg_padder_if #(.IN_BYTES(4)) bus4 ();

  sha256_msg_padder #(.IN_BYTES(1), .MSG_CNT_W(32)) u_dut1 (
    .i_clock (clk),
    .i_reset (rst_n),
    .io_bus  (bus1.slave)
  );

  sha256_msg_padder #(.IN_BYTES(4), .MSG_CNT_W(32)) u_dut4 (
    .i_clock (clk),
    .i_reset (rst_n),
    .io_bus  (bus4.slave)
  );

  int checks = 0;
  int errors = 0;
  int sel = 4;
  bit bp_en = 1'b0;
  int stall_cnt = 0;
  int rx_last_cnt = 0;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] rx_q[$];
  logic [31:0] abc_ref[$];
  logic [7:0]  msg[$];

  logic        m_valid, m_ready, m_last, m_in_ready;
  logic [31:0] m_data;
  logic [3:0]  m_idx;
  logic        p_stall = 1'b0;
  logic [31:0] p_data;
  logic [3:0]  p_idx;
  logic        p_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rx_at(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 32'hDEAD_BEEF;
  endfunction

  always_comb begin
    if (sel == 1) begin
      m_valid = bus1.word_valid; m_ready = bus1.word_ready; m_last = bus1.msg_last;
      m_data  = bus1.word_data;  m_idx   = bus1.word_index; m_in_ready = bus1.in_ready;
    end else begin
      m_valid = bus4.word_valid; m_ready = bus4.word_ready; m_last = bus4.msg_last;
      m_data  = bus4.word_data;  m_idx   = bus4.word_index; m_in_ready = bus4.in_ready;
    end
  end

  // downstream ready, changed just after each rising edge
  initial begin
    int unsigned r;
    bus1.word_ready = 1'b1;
    bus4.word_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      r = bp_en ? $urandom_range(0, 1) : 1;
      bus1.word_ready = r[0];
      bus4.word_ready = r[0];
    end
  end

  // output monitor: stability while stalled, in_ready while full, scoreboard compare
  always @(negedge clk) begin
    if (!rst_n) begin
      p_stall <= 1'b0;
    end else begin
      if (p_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, p_data);
        chk("stall_index", m_idx, p_idx);
        chk("stall_last", m_last, p_last);
      end
      if (m_valid && !m_ready) begin
        stall_cnt++;
        chk("in_ready_while_full", m_in_ready, 0);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {32'h0, m_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", m_data, e.data);
          chk("word_index", m_idx, e.idx);
          chk("msg_last", m_last, e.last);
          rx_q.push_back(m_data);
          if (m_last) rx_last_cnt++;
        end
      end
      p_stall <= m_valid && !m_ready;
      p_data  <= m_data;
      p_idx   <= m_idx;
      p_last  <= m_last;
    end
  end

  task automatic push_model();
    logic [7:0]  p[$];
    logic [63:0] bl;
    int          nw;
    exp_t        x;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    nw = p.size() / 4;
    for (int w = 0; w < nw; w++) begin
      x.data = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
      x.idx  = 4'(w % 16);
      x.last = (w == nw - 1);
      exp_q.push_back(x);
    end
  endtask

  task automatic drive_beat(input int s, input logic [31:0] d, input int nb, input bit last);
    int cyc = 0;
    if (s == 1) begin
      bus1.in_valid = 1'b1; bus1.in_data = d[31:24]; bus1.in_bytes = 1'(nb); bus1.in_last = last;
    end else begin
      bus4.in_valid = 1'b1; bus4.in_data = d; bus4.in_bytes = 3'(nb); bus4.in_last = last;
    end
    while (!((s == 1) ? bus1.in_ready : bus4.in_ready) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 500) chk("in_ready_timeout", cyc, 0);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    bus4.in_valid = 1'b0;
  endtask

  task automatic send_msg(input int s);
    int pos = 0;
    int nb;
    logic [31:0] d;
    push_model();
    if (msg.size() == 0) drive_beat(s, 32'h0, 0, 1'b1);
    while (pos < msg.size()) begin
      nb = (msg.size() - pos < s) ? msg.size() - pos : s;
      d  = '0;
      for (int j = 0; j < nb; j++) d[31-8*j -: 8] = msg[pos+j];
      drive_beat(s, d, nb, (pos + nb) == msg.size());
      pos += nb;
    end
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic set_str(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
  endtask

  task automatic new_test();
    rx_q.delete();
    rx_last_cnt = 0;
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{len: 3,  is_abc: 1'b1, w0: 32'h6162_6380, wlast: 32'h0000_0018, nwords: 16};
    vecs[1] = '{len: 55, is_abc: 1'b0, w0: 32'h6162_6364, wlast: 32'h0000_01B8, nwords: 16};
    vecs[2] = '{len: 56, is_abc: 1'b0, w0: 32'h6162_6364, wlast: 32'h0000_01C0, nwords: 32};
    vecs[3] = '{len: 0,  is_abc: 1'b0, w0: 32'h8000_0000, wlast: 32'h0000_0000, nwords: 16};
    vecs[4] = '{len: 60, is_abc: 1'b0, w0: 32'h6162_6364, wlast: 32'h0000_01E0, nwords: 32};

    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_bytes = '0; bus1.in_last = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_bytes = '0; bus4.in_last = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_in_ready1", bus1.in_ready, 0);
    chk("rst_word_valid1", bus1.word_valid, 0);
    chk("rst_word_data1", bus1.word_data, 0);
    chk("rst_word_index1", bus1.word_index, 0);
    chk("rst_msg_last1", bus1.msg_last, 0);
    chk("rst_in_ready4", bus4.in_ready, 0);
    chk("rst_word_valid4", bus4.word_valid, 0);
    chk("rst_word_data4", bus4.word_data, 0);
    chk("rst_word_index4", bus4.word_index, 0);
    chk("rst_msg_last4", bus4.msg_last, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 15-byte string, one byte per beat
    sel = 1;
    new_test();
    set_str("projectfpga.com");
    send_msg(1);
    wait_idle();
    chk("pf_nwords", rx_q.size(), 16);
    chk("pf_w0", rx_at(0), 32'h7072_6F6A);
    chk("pf_w1", rx_at(1), 32'h6563_7466);
    chk("pf_w2", rx_at(2), 32'h7067_612E);
    chk("pf_w3", rx_at(3), 32'h636F_6D80);
    chk("pf_w4", rx_at(4), 32'h0);
    chk("pf_w14", rx_at(14), 32'h0);
    chk("pf_w15", rx_at(15), 32'h0000_0078);
    chk("pf_last_cnt", rx_last_cnt, 1);

    // four bytes per beat, table of lengths around the block boundary
    sel = 4;
    for (int v = 0; v < 5; v++) begin
      new_test();
      if (vecs[v].is_abc) set_str("abc");
      else begin
        msg.delete();
        for (int i = 0; i < vecs[v].len; i++) msg.push_back(8'(8'h61 + (i % 26)));
      end
      send_msg(4);
      wait_idle();
      chk("vec_nwords", rx_q.size(), vecs[v].nwords);
      chk("vec_w0", rx_at(0), vecs[v].w0);
      chk("vec_wlast", rx_at(vecs[v].nwords - 1), vecs[v].wlast);
      chk("vec_last_cnt", rx_last_cnt, 1);
      if (vecs[v].is_abc) abc_ref = rx_q;
      if (vecs[v].len == 56) begin
        chk("b56_w14", rx_at(14), 32'h8000_0000);
        chk("b56_w15", rx_at(15), 32'h0);
        chk("b56_w16", rx_at(16), 32'h0);
        chk("b56_w30", rx_at(30), 32'h0);
      end
    end

    // random downstream stalls on "abc"
    new_test();
    stall_cnt = 0;
    bp_en = 1'b1;
    set_str("abc");
    send_msg(4);
    wait_idle();
    bp_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("bp_nwords", rx_q.size(), 16);
    for (int i = 0; i < 16; i++) chk("bp_word", rx_at(i), abc_ref[i]);
    chk("bp_stalls_seen", stall_cnt > 0, 1);

    // reset after five bytes of a message, then a clean "abc"
    sel = 1;
    new_test();
    set_str("projectfpga.com");
    exp_q.push_back('{data: 32'h7072_6F6A, idx: 4'd0, last: 1'b0});
    for (int i = 0; i < 5; i++) drive_beat(1, {msg[i], 24'h0}, 1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", bus1.in_ready, 0);
    chk("arst_word_valid", bus1.word_valid, 0);
    chk("arst_word_data", bus1.word_data, 0);
    chk("arst_word_index", bus1.word_index, 0);
    chk("arst_msg_last", bus1.msg_last, 0);
    chk("arst_first_word_seen", rx_q.size(), 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    new_test();
    set_str("abc");
    send_msg(1);
    wait_idle();
    chk("post_rst_nwords", rx_q.size(), 16);
    for (int i = 0; i < 16; i++) chk("post_rst_word", rx_at(i), abc_ref[i]);
    chk("post_rst_last_cnt", rx_last_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
